// File: rtl/iterative_normalizer.sv
// Multi-cycle left-normalizer: binary-search shift, one power-of-two stride per cycle.
// Optional ITER_NORMALIZER_EARLY_EXIT_EN finishes as soon as the working MSB is set.
module iterative_normalizer #(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = $clog2(WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [COUNT_BITS-1:0] count_o,
  output logic                  allzero_o,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [WIDTH-1:0]      working;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] step;

  logic [COUNT_BITS:0]   stride;
  logic [WIDTH-1:0]      hi_mask;
  logic [WIDTH-1:0]      next_working;
  logic [COUNT_BITS-1:0] next_count;
  logic                  top_zero;
  logic                  early_exit;
  logic                  last_step;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid_o holds with stable data until ready_i takes it, ready_o is high only in IDLE.
  assign ready_o   = (state == IDLE);
  assign state_dbg = state;

`ifdef ITER_NORMALIZER_EARLY_EXIT_EN
  assign early_exit = working[WIDTH-1];
`else
  assign early_exit = 1'b0;
`endif

  assign last_step = (step == '0);

  // Test the top 2**step bits; if all zero, shift them out and record that count bit.
  always_comb begin
    stride       = (COUNT_BITS+1)'(1) << step;
    hi_mask      = ~({WIDTH{1'b1}} >> stride);
    top_zero     = ((working & hi_mask) == '0);
    next_working = working;
    next_count   = count;
    if (top_zero) begin
      next_working = working << stride;
      next_count   = count | (COUNT_BITS'(1) << step);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      working   <= '0;
      count     <= '0;
      step      <= '0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      count_o   <= '0;
      allzero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            working <= data_i;
            count   <= '0;
            step    <= COUNT_BITS'(COUNT_BITS-1);
            if (data_i == '0) begin
              state     <= DONE;
              valid_o   <= 1'b1;
              data_o    <= '0;
              count_o   <= '0;
              allzero_o <= 1'b1;
            end else begin
              state     <= SHIFT;
              allzero_o <= 1'b0;
            end
          end
        end
        SHIFT: begin
          if (early_exit) begin
            state   <= DONE;
            valid_o <= 1'b1;
            data_o  <= working;
            count_o <= count;
          end else begin
            working <= next_working;
            count   <= next_count;
            if (last_step) begin
              state   <= DONE;
              valid_o <= 1'b1;
              data_o  <= next_working;
              count_o <= next_count;
            end else begin
              step <= step - COUNT_BITS'(1);
            end
          end
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
